bcd_seq_gen: RTL and testbench

Multi-digit BCD sequence generator that sits directly upstream of the BCD-to-Gray converter. It produces a stream of legal BCD codes: counting up or down, loadable, with wrap or saturate at the ends. Each code is presented on a valid/ready handshake, and the block drives the converter's `enable`. Digit 0 (least significant) is the nibble that feeds a single-digit converter.

---
 rtl/bcd_seq_gen.sv | 164 ++++++++++++++++
 tb/tb_bcd_seq_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_gen.sv
// Multi-digit BCD up/down counter presented on a valid/ready handshake.
// It drives the enable of a downstream BCD-to-Gray converter.
module bcd_seq_gen #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  output logic                  conv_en,
  output logic                  tc,
  output logic                  done,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [W-1:0]      r_bcd;
  logic [W-1:0]      w_bcd_next;
  logic [W-1:0]      w_bcd_step;
  logic              r_valid;
  logic              w_valid_next;
  logic              r_tc;
  logic              w_tc_next;
  logic              r_done;
  logic              w_done_next;
  logic              r_load_err;
  logic              w_load_err_next;
  logic [DIGITS-1:0] w_nib_ok;
  logic              w_load_ok;
  logic              w_accept;
  logic              w_at_end;
  logic              w_carry;
  logic [3:0]        w_digit;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib_chk
      assign w_nib_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  assign w_load_ok = &w_nib_ok;
  assign w_accept  = r_valid & out_ready;

  // Ripple the decimal carry (up) or borrow (down) from digit 0; a carry
  // falling out of the top digit marks the all-nines / zero end of range.
  always_comb begin
    w_bcd_step = r_bcd;
    w_carry    = 1'b1;
    w_digit    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_digit = r_bcd[4*i +: 4];
      if (w_carry) begin
        if (up) begin
          if (w_digit == 4'd9) begin
            w_bcd_step[4*i +: 4] = 4'd0;
          end else begin
            w_bcd_step[4*i +: 4] = w_digit + 4'd1;
            w_carry = 1'b0;
          end
        end else begin
          if (w_digit == 4'd0) begin
            w_bcd_step[4*i +: 4] = 4'd9;
          end else begin
            w_bcd_step[4*i +: 4] = w_digit - 4'd1;
            w_carry = 1'b0;
          end
        end
      end
    end
    w_at_end = w_carry;
  end

  always_comb begin
    w_state_next    = r_state;
    w_bcd_next      = r_bcd;
    w_valid_next    = r_valid;
    w_done_next     = r_done;
    w_tc_next       = 1'b0;
    w_load_err_next = 1'b0;
    if (load) begin
      // A rejected load freezes everything for the cycle and only flags it.
      if (w_load_ok) begin
        w_bcd_next   = load_val;
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
      end else begin
        w_load_err_next = 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            w_state_next = ST_SHOW;
            w_valid_next = 1'b1;
          end
        end
        ST_SHOW: begin
          if (w_accept) begin
            if (w_at_end && (WRAP == 0)) begin
              w_state_next = ST_STOP;
              w_valid_next = 1'b0;
              w_done_next  = 1'b1;
            end else begin
              w_bcd_next   = w_bcd_step;
              w_tc_next    = w_at_end;
              w_state_next = en ? ST_SHOW : ST_IDLE;
              w_valid_next = en;
            end
          end
        end
        ST_STOP: begin
          w_valid_next = 1'b0;
          w_done_next  = 1'b1;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_valid_next = 1'b0;
          w_done_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bcd      <= '0;
      r_valid    <= 1'b0;
      r_tc       <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bcd      <= w_bcd_next;
      r_valid    <= w_valid_next;
      r_tc       <= w_tc_next;
      r_done     <= w_done_next;
      r_load_err <= w_load_err_next;
    end
  end

  assign bcd       = r_bcd;
  assign out_valid = r_valid;
  assign conv_en   = r_valid;
  assign tc        = r_tc;
  assign done      = r_done;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_seq_gen.sv
// Directed bench: one wrapping and one saturating instance share the stimulus.
module tb_bcd_seq_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic       out_ready;

  logic [7:0] w_bcd, s_bcd;
  logic       w_valid, w_conv, w_tc, w_done, w_lerr;
  logic       s_valid, s_conv, s_tc, s_done, s_lerr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_seq_gen #(.DIGITS(2), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .out_ready(out_ready), .bcd(w_bcd), .out_valid(w_valid), .conv_en(w_conv),
    .tc(w_tc), .done(w_done), .load_err(w_lerr)
  );

  bcd_seq_gen #(.DIGITS(2), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .out_ready(out_ready), .bcd(s_bcd), .out_valid(s_valid), .conv_en(s_conv),
    .tc(s_tc), .done(s_done), .load_err(s_lerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_bcd;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00; out_ready = 1'b0;
    #3;
    chk("rst_bcd", w_bcd, 8'h00);
    chk("rst_valid", w_valid, 1'b0);
    chk("rst_conv", w_conv, 1'b0);
    chk("rst_tc", w_tc, 1'b0);
    chk("rst_done", s_done, 1'b0);
    chk("rst_lerr", w_lerr, 1'b0);
    step();
    reset = 1'b0;

    // Free-running count up from zero
    en = 1'b1; up = 1'b1; out_ready = 1'b1;
    step();
    chk("up_valid", w_valid, 1'b1);
    chk("up_bcd0", w_bcd, 8'h00);
    for (int k = 1; k <= 11; k++) begin
      step();
      exp_bcd = 8'((k / 10) * 16 + (k % 10));
      chk("up_bcd", w_bcd, exp_bcd);
      chk("up_nib_ok", {31'd0, (w_bcd[3:0] <= 4'd9) && (w_bcd[7:4] <= 4'd9)}, 1'b1);
    end

    // Load 98 (coinciding with an accept) and wrap through 99 -> 00
    load = 1'b1; load_val = 8'h98; en = 1'b0;
    step();
    chk("ld98_bcd", w_bcd, 8'h98);
    chk("ld98_valid", w_valid, 1'b0);
    load = 1'b0; en = 1'b1;
    step();
    chk("wr_bcd98", w_bcd, 8'h98);
    chk("wr_conv98", w_conv, 1'b1);
    step();
    chk("wr_bcd99", w_bcd, 8'h99);
    chk("wr_tc99", w_tc, 1'b0);
    step();
    chk("wr_bcd00", w_bcd, 8'h00);
    chk("wr_tc00", w_tc, 1'b1);
    chk("wr_conv00", w_conv, 1'b1);
    step();
    chk("wr_bcd01", w_bcd, 8'h01);
    chk("wr_tc01", w_tc, 1'b0);
    en = 1'b0;
    step();
    chk("en0_bcd", w_bcd, 8'h02);
    chk("en0_valid", w_valid, 1'b0);

    // Saturating count down to zero, then STOP
    load = 1'b1; load_val = 8'h01; up = 1'b0;
    step();
    chk("ld01_bcd", s_bcd, 8'h01);
    load = 1'b0; en = 1'b1;
    step();
    chk("sat_bcd01", s_bcd, 8'h01);
    chk("sat_valid", s_valid, 1'b1);
    step();
    chk("sat_bcd00", s_bcd, 8'h00);
    step();
    chk("sat_stop_bcd", s_bcd, 8'h00);
    chk("sat_stop_val", s_valid, 1'b0);
    chk("sat_done", s_done, 1'b1);
    chk("sat_tc", s_tc, 1'b0);
    chk("dn_wrap_bcd", w_bcd, 8'h99);
    chk("dn_wrap_tc", w_tc, 1'b1);
    step();
    step();
    chk("stop_hold_v", s_valid, 1'b0);
    chk("stop_hold_d", s_done, 1'b1);
    chk("stop_hold_b", s_bcd, 8'h00);
    load = 1'b1; load_val = 8'h50;
    step();
    chk("ld50_bcd", s_bcd, 8'h50);
    chk("ld50_done", s_done, 1'b0);
    chk("ld50_valid", s_valid, 1'b0);

    // Stall at 37 while toggling up, then accept counting down
    load_val = 8'h37; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; out_ready = 1'b0;
    step();
    chk("stl_valid", w_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      up = ~up;
      step();
      chk("stl_bcd", w_bcd, 8'h37);
      chk("stl_valid", w_valid, 1'b1);
    end
    out_ready = 1'b1; up = 1'b0;
    step();
    chk("stl_next", w_bcd, 8'h36);

    // Rejected load, then a load coinciding with an accept
    en = 1'b0;
    step();
    chk("idle_bcd35", w_bcd, 8'h35);
    load = 1'b1; load_val = 8'h4C;
    step();
    chk("lerr_pulse", w_lerr, 1'b1);
    chk("lerr_bcd", w_bcd, 8'h35);
    chk("lerr_valid", w_valid, 1'b0);
    load = 1'b0;
    step();
    chk("lerr_clear", w_lerr, 1'b0);
    chk("lerr_bcd2", w_bcd, 8'h35);
    en = 1'b1;
    step();
    chk("pre_ld_val", w_valid, 1'b1);
    load = 1'b1; load_val = 8'h20;
    step();
    chk("ldacc_bcd", w_bcd, 8'h20);
    chk("ldacc_valid", w_valid, 1'b0);
    chk("ldacc_tc", w_tc, 1'b0);
    load = 1'b0;

    // Asynchronous reset mid-stream at 55
    load = 1'b1; load_val = 8'h54; up = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    chk("pre_rst_bcd", w_bcd, 8'h55);
    chk("pre_rst_val", w_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_bcd", w_bcd, 8'h00);
    chk("arst_valid", w_valid, 1'b0);
    chk("arst_conv", w_conv, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("rel_valid", w_valid, 1'b1);
    chk("rel_bcd00", w_bcd, 8'h00);
    step();
    chk("rel_bcd01", w_bcd, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
